sl_receiver_fifo: RTL and testbench
===================================

Name: sl_receiver_fifo

Overview:
- Next-generation two-wire serial-line (SL) receiver for the 16 MHz clock domain.
- Decodes pulses on the zeroes and ones lines into words of configurable length, with optional odd-parity checking.
- Buffers complete words in a FIFO with a valid/ready read port, so software or a bus bridge can drain bursts of words instead of one buffered word.
- Adds an inter-bit gap timeout, overflow detection, sticky error flags and a maskable interrupt.

Parameters:
- MAX_BITS, 32: maximum data bits per word; width of rd_data.
- FIFO_DEPTH, 4: number of word entries; power of two, minimum 2.
- FILT_LEN, 4: consecutive equal samples needed to accept a line level.
- STROBE_POS, 3: cycles after the filtered falling edge at which both lines are sampled.
- PULSE_MAX, 8: cycle limit from the edge to the end of the pulse.
- GAP_MAX, 64: cycle limit between bits while a word is in progress.
- CONFIG_WIDTH, 16: config register width.
- STATUS_WIDTH, 16: status register width.

Ports:
- clk  in  1  system clock, 16 MHz.
- rst_n  in  1  asynchronous active-low reset.
- serial_line_zeroes_a  in  1  async zeroes line; idle high.
- serial_line_ones_a  in  1  async ones line; idle high.
- wr_config_w  in  CONFIG_WIDTH  new config value.
- wr_enable  in  1  config write strobe.
- r_config_w  out  CONFIG_WIDTH  current config.
- status_clr  in  1  clears all sticky flags.
- status_w  out  STATUS_WIDTH  status.
- rd_valid  out  1  FIFO head valid.
- rd_ready  in  1  consumer accepts the head.
- rd_data  out  MAX_BITS  received data, LSB is the first bit received; unused MSBs are 0.
- rd_perr  out  1  head word has a parity error.
- irq  out  1  interrupt request.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n. All flops clear on reset.
- Reset values:
  - config = 0x0010 (PCE=0, BQ=8).
  - status = 0, FIFO empty, rd_valid = 0, rd_data = 0, rd_perr = 0, irq = 0.
- Input conditioning:
  - Each line passes through a 2-FF synchroniser, then a FILT_LEN-sample filter.
  - The filtered level changes only after FILT_LEN equal consecutive samples.
- Config fields:
  - PCE, bit 0: parity check enable.
  - BQ, bits 6:1: data-bit count.
  - IRQM, bits 9:8: bit 8 enables the irq on word available; bit 9 enables the irq on any sticky error.
- Config write rules:
  - A write is accepted only when no word is in progress and BQ is even with 8 ≤ BQ ≤ MAX_BITS.
  - Otherwise the write is ignored and sticky flag CFE is set.
- FSM states: IDLE, EDGE, SAMPLE, WAIT_END, CHECK, ERR.
- IDLE → EDGE: on a filtered falling edge of either line. The cycle counter is cleared.
- EDGE → SAMPLE: when the counter reaches STROBE_POS.
- SAMPLE, line decode:
  - zeroes low, ones high: bit 0.
  - ones low, zeroes high: bit 1.
  - both low: stop.
  - both high: level error, go to ERR.
- Data bits:
  - Shift the bit in at position bit_cnt.
  - XOR the bit into the parity accumulator; the accumulator starts at 1.
  - Increment bit_cnt.
  - If bit_cnt exceeds BQ+1, flag a length error and go to ERR.
- Stop:
  - Go to CHECK if bit_cnt == BQ+1; otherwise flag a length error and go to ERR.
- WAIT_END:
  - Go to IDLE when both filtered lines are high.
  - Flag a level error and go to ERR if the counter exceeds PULSE_MAX.
- Gap timeout:
  - While bit_cnt > 0 in IDLE, a gap counter runs.
  - If it reaches GAP_MAX, set sticky TOF, discard the partial word and return to IDLE.
- CHECK:
  - Parity error = PCE AND accumulator ≠ 0, i.e. data plus parity bit carry an even count of ones.
  - Push {data with the parity bit removed, perr} to the FIFO. A word with a parity error is still pushed, and sticky PEF is set.
  - If the FIFO is full, drop the word and set sticky OVF.
  - Then go to WAIT_END (the stop pulse).
- ERR:
  - Set sticky LEF or WLE as appropriate.
  - Discard the partial word, clear bit_cnt and parity, wait until both lines are high, then go to IDLE.
- Read latency and handshake:
  - Stop sampled at cycle S; FIFO write at S+1; rd_valid = 1 at S+2 if the FIFO was empty.
  - A pop occurs on rd_valid & rd_ready.
  - Simultaneous push and pop when full: the push succeeds and no OVF is set.
- Status bits:
  - 0: WRP, word in progress.
  - 1: WLE.
  - 2: PEF.
  - 3: LEF.
  - 4: OVF.
  - 5: TOF.
  - 6: CFE.
  - 11:8: FIFO count.
  - Bits 6:1 are sticky until status_clr. If status_clr coincides with a set event, set wins.
- irq: registered; = (IRQM[0] & rd_valid) | (IRQM[1] & |sticky).

Optional Feature:
- Macro SL_RX_ERR_CNT_EN.
- With the macro: adds output err_cnt_w[15:0], holding four 4-bit saturating counters {OVF, LEF, WLE, PEF}; each counter increments on its event and clears on status_clr.
- Without the macro: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Package sl_pkg:
  - FSM state enum.
  - Config field positions PCE, BQL, BQH, IRQM.
  - Status bit positions.
  - Reset config value 0x0010.
- Sub-module sl_rx_fifo: synchronous FIFO, parameters WIDTH and DEPTH, with full, empty and count outputs and push/pop.

Test Plan:
- Default config, send 8 data bits 0xA5 with correct odd parity, then stop → rd_valid at S+2, rd_data = 0x000000A5, rd_perr = 0, count = 1.
- PCE = 1, send 0x01 with wrong parity → word pushed with rd_perr = 1, PEF = 1.
- Send 5 words with rd_ready held low, FIFO_DEPTH = 4 → count = 4, OVF = 1, the first four words are intact on drain.
- Stop after 6 bits (BQ = 8) → WLE = 1, nothing pushed; next valid word received normally.
- Ones line held low 20 cycles → LEF = 1; bits stalled for 70 cycles mid-word → TOF = 1, partial word discarded.
- Write BQ = 7, then BQ = 16 mid-word → both writes ignored; write BQ = 16 while idle → config updates.

Source files
------------

// File: rtl/sl_pkg.sv
// Shared FSM state type, register field positions and line decode helper for the
// serial-line receiver with word FIFO.
package sl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EDGE,
        S_SAMPLE,
        S_WAIT_END,
        S_CHECK,
        S_ERR
    } sl_state_e;

    typedef enum logic [1:0] {
        LN_BIT0,
        LN_BIT1,
        LN_STOP,
        LN_LEVEL_ERR
    } line_code_e;

    // Config register fields
    localparam int CFG_PCE    = 0;
    localparam int CFG_BQL    = 1;
    localparam int CFG_BQH    = 6;
    localparam int CFG_IRQM_L = 8;
    localparam int CFG_IRQM_H = 9;
    localparam logic [15:0] CFG_RESET = 16'h0010;

    // Status register fields
    localparam int ST_WRP   = 0;
    localparam int ST_WLE   = 1;
    localparam int ST_PEF   = 2;
    localparam int ST_LEF   = 3;
    localparam int ST_OVF   = 4;
    localparam int ST_TOF   = 5;
    localparam int ST_CFE   = 6;
    localparam int ST_CNT_L = 8;
    localparam int ST_CNT_H = 11;

    // Lines idle high; a low line carries the symbol.
    function automatic line_code_e decode_lines(input logic zeroes, input logic ones);
        case ({zeroes, ones})
            2'b01:   return LN_BIT0;
            2'b10:   return LN_BIT1;
            2'b00:   return LN_STOP;
            default: return LN_LEVEL_ERR;
        endcase
    endfunction

endpackage

// File: rtl/sl_rx_fifo.sv
// Synchronous word FIFO; a push into a full FIFO is accepted only when a pop
// happens in the same cycle.
module sl_rx_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // NOTE: the storage array is reset too, so no flop powers up unknown; the
    // pointers alone would suffice functionally, but every register clears here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sl_receiver_fifo.sv
// Two-wire serial-line receiver: conditions both lines, decodes words with optional
// odd parity into a FIFO. Define SL_RX_ERR_CNT_EN to add the err_cnt_w counters.
module sl_receiver_fifo
    import sl_pkg::*;
#(
    parameter int MAX_BITS     = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int FILT_LEN     = 4,
    parameter int STROBE_POS   = 3,
    parameter int PULSE_MAX    = 8,
    parameter int GAP_MAX      = 64,
    parameter int CONFIG_WIDTH = 16,
    parameter int STATUS_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    serial_line_zeroes_a,
    input  logic                    serial_line_ones_a,
    input  logic [CONFIG_WIDTH-1:0] wr_config_w,
    input  logic                    wr_enable,
    output logic [CONFIG_WIDTH-1:0] r_config_w,
    input  logic                    status_clr,
    output logic [STATUS_WIDTH-1:0] status_w,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [MAX_BITS-1:0]     rd_data,
    output logic                    rd_perr,
    output logic                    irq
`ifdef SL_RX_ERR_CNT_EN
    ,
    output logic [15:0]             err_cnt_w
`endif
);

    localparam int SRW  = MAX_BITS + 1;
    localparam int BCW  = $clog2(MAX_BITS + 3);
    localparam int CW   = $clog2(PULSE_MAX + STROBE_POS + 2);
    localparam int GW   = $clog2(GAP_MAX + 1);
    localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

    // Line conditioning: index 0 is the zeroes line, index 1 the ones line.
    logic [1:0]          sync_q1;
    logic [1:0]          sync_q2;
    logic [FILT_LEN-1:0] hist_z;
    logic [FILT_LEN-1:0] hist_o;
    logic [1:0]          filt;
    logic [1:0]          filt_d;
    logic                fall_any;
    logic                both_high;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
            hist_z  <= '0;
            hist_o  <= '0;
            filt    <= '0;
            filt_d  <= '0;
        end else begin
            sync_q1 <= {serial_line_ones_a, serial_line_zeroes_a};
            sync_q2 <= sync_q1;
            hist_z  <= {hist_z[FILT_LEN-2:0], sync_q2[0]};
            hist_o  <= {hist_o[FILT_LEN-2:0], sync_q2[1]};
            filt_d  <= filt;
            if (&hist_z)       filt[0] <= 1'b1;
            else if (~|hist_z) filt[0] <= 1'b0;
            if (&hist_o)       filt[1] <= 1'b1;
            else if (~|hist_o) filt[1] <= 1'b0;
        end
    end

    assign fall_any  = |(filt_d & ~filt);
    assign both_high = &filt;

    // Configuration
    logic [CONFIG_WIDTH-1:0] config_q;
    logic [5:0]              bq;
    logic [5:0]              wr_bq;
    logic                    bq_ok;
    logic                    cfg_accept;
    logic [BCW-1:0]          bq_p1;

    assign bq         = config_q[CFG_BQH:CFG_BQL];
    assign wr_bq      = wr_config_w[CFG_BQH:CFG_BQL];
    assign bq_ok      = ~wr_bq[0] && (wr_bq >= 6'd8) && (int'(wr_bq) <= MAX_BITS);
    assign bq_p1      = BCW'(bq) + BCW'(1);
    assign r_config_w = config_q;

    // Receive FSM and datapath
    sl_state_e      state, state_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [BCW-1:0] bit_cnt, bit_cnt_n;
    logic [SRW-1:0] shreg, shreg_n;
    logic [GW-1:0]  gap_cnt, gap_n;
    logic           ones_par, ones_par_n;
    line_code_e     code;
    logic           push;
    logic           ev_wle;
    logic           ev_lef;
    logic           ev_tof;
    logic           wrp;

    assign wrp  = (state != S_IDLE) || (bit_cnt != '0);
    assign code = decode_lines(filt[0], filt[1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            gap_cnt  <= '0;
            ones_par <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_cnt  <= bit_cnt_n;
            shreg    <= shreg_n;
            gap_cnt  <= gap_n;
            ones_par <= ones_par_n;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_n    = state;
        cnt_n      = (cnt == '1) ? cnt : cnt + 1'b1;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        ones_par_n = ones_par;
        gap_n      = '0;
        push       = 1'b0;
        ev_wle     = 1'b0;
        ev_lef     = 1'b0;
        ev_tof     = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (fall_any) begin
                    state_n = S_EDGE;
                end else if (bit_cnt != '0) begin
                    if (gap_cnt == GW'(GAP_MAX - 1)) begin
                        ev_tof     = 1'b1;
                        bit_cnt_n  = '0;
                        shreg_n    = '0;
                        ones_par_n = 1'b0;
                    end else begin
                        gap_n = gap_cnt + 1'b1;
                    end
                end
            end
            S_EDGE: begin
                if (cnt == CW'(STROBE_POS)) state_n = S_SAMPLE;
            end
            S_SAMPLE: begin
                case (code)
                    LN_BIT0, LN_BIT1: begin
                        if (int'(bit_cnt) < SRW) shreg_n[bit_cnt] = (code == LN_BIT1);
                        ones_par_n = ones_par ^ (code == LN_BIT1);
                        bit_cnt_n  = bit_cnt + 1'b1;
                        if (bit_cnt_n > bq_p1) begin
                            ev_wle  = 1'b1;
                            state_n = S_ERR;
                        end else begin
                            state_n = S_WAIT_END;
                        end
                    end
                    LN_STOP: begin
                        if (bit_cnt == bq_p1) begin
                            state_n = S_CHECK;
                        end else begin
                            ev_wle  = 1'b1;
                            state_n = S_ERR;
                        end
                    end
                    default: begin
                        ev_lef  = 1'b1;
                        state_n = S_ERR;
                    end
                endcase
            end
            S_WAIT_END: begin
                if (both_high) begin
                    state_n = S_IDLE;
                end else if (cnt > CW'(PULSE_MAX)) begin
                    ev_lef  = 1'b1;
                    state_n = S_ERR;
                end
            end
            S_CHECK: begin
                push       = 1'b1;
                bit_cnt_n  = '0;
                shreg_n    = '0;
                ones_par_n = 1'b0;
                state_n    = S_WAIT_END;
            end
            S_ERR: begin
                bit_cnt_n  = '0;
                shreg_n    = '0;
                ones_par_n = 1'b0;
                if (both_high) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Drop the parity bit at position BQ and anything above it.
    logic [MAX_BITS-1:0] word_data;
    logic                word_perr;

    always_comb begin
        word_data = shreg[MAX_BITS-1:0];
        for (int i = 0; i < MAX_BITS; i++) begin
            if (i >= int'(bq)) word_data[i] = 1'b0;
        end
    end

    // ones_par tracks data+parity ones; the odd-parity accumulator is its inverse.
    assign word_perr = config_q[CFG_PCE] & ~ones_par;

    // Word FIFO
    logic [MAX_BITS:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNTW-1:0]   fifo_count;
    logic              pop;

    assign rd_valid = ~fifo_empty;
    assign pop      = rd_valid & rd_ready;
    assign rd_data  = fifo_rdata[MAX_BITS-1:0];
    assign rd_perr  = fifo_rdata[MAX_BITS];

    sl_rx_fifo #(
        .WIDTH (MAX_BITS + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({word_perr, word_data}),
        .pop       (pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Sticky flags, config register and interrupt
    logic [ST_CFE:ST_WLE] sticky_q;
    logic [ST_CFE:ST_WLE] sticky_ev;

    assign cfg_accept = wr_enable & bq_ok & ~wrp;

    always_comb begin
        sticky_ev         = '0;
        sticky_ev[ST_WLE] = ev_wle;
        sticky_ev[ST_PEF] = push & word_perr;
        sticky_ev[ST_LEF] = ev_lef;
        sticky_ev[ST_OVF] = push & fifo_full & ~pop;
        sticky_ev[ST_TOF] = ev_tof;
        sticky_ev[ST_CFE] = wr_enable & ~cfg_accept;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            config_q <= CONFIG_WIDTH'(CFG_RESET);
            sticky_q <= '0;
            irq      <= 1'b0;
        end else begin
            if (cfg_accept) config_q <= wr_config_w;
            sticky_q <= (status_clr ? '0 : sticky_q) | sticky_ev;
            irq      <= (config_q[CFG_IRQM_L] & rd_valid) | (config_q[CFG_IRQM_H] & |sticky_q);
        end
    end

    always_comb begin
        status_w                    = '0;
        status_w[ST_WRP]            = wrp;
        status_w[ST_CFE:ST_WLE]     = sticky_q;
        status_w[ST_CNT_H:ST_CNT_L] = (ST_CNT_H - ST_CNT_L + 1)'(fifo_count);
    end

`ifdef SL_RX_ERR_CNT_EN
    logic [3:0] cnt_ovf, cnt_lef, cnt_wle, cnt_pef;

    function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic clr, input logic ev);
        logic [3:0] base;
        base = clr ? 4'd0 : v;
        return (ev && base != 4'hF) ? base + 4'd1 : base;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_ovf <= '0;
            cnt_lef <= '0;
            cnt_wle <= '0;
            cnt_pef <= '0;
        end else begin
            cnt_ovf <= sat_inc(cnt_ovf, status_clr, sticky_ev[ST_OVF]);
            cnt_lef <= sat_inc(cnt_lef, status_clr, sticky_ev[ST_LEF]);
            cnt_wle <= sat_inc(cnt_wle, status_clr, sticky_ev[ST_WLE]);
            cnt_pef <= sat_inc(cnt_pef, status_clr, sticky_ev[ST_PEF]);
        end
    end

    assign err_cnt_w = {cnt_ovf, cnt_lef, cnt_wle, cnt_pef};
`endif

endmodule

// File: tb/tb_sl_receiver_fifo.sv
// Scoreboard bench for sl_receiver_fifo: directed words on the two lines, with a
// monitor popping expected words whenever the read port hands one over.
`timescale 1ns/1ps
module tb_sl_receiver_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        serial_line_zeroes_a = 1'b1;
    logic        serial_line_ones_a = 1'b1;
    logic [15:0] wr_config_w = '0;
    logic        wr_enable = 1'b0;
    logic [15:0] r_config_w;
    logic        status_clr = 1'b0;
    logic [15:0] status_w;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [31:0] rd_data;
    logic        rd_perr;
    logic        irq;
`ifdef SL_RX_ERR_CNT_EN
    logic [15:0] err_cnt_w;
`endif

    typedef struct {
        logic [31:0] data;
        logic        perr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   fails = 0;

    sl_receiver_fifo dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .serial_line_zeroes_a (serial_line_zeroes_a),
        .serial_line_ones_a   (serial_line_ones_a),
        .wr_config_w          (wr_config_w),
        .wr_enable            (wr_enable),
        .r_config_w           (r_config_w),
        .status_clr           (status_clr),
        .status_w             (status_w),
        .rd_valid             (rd_valid),
        .rd_ready             (rd_ready),
        .rd_data              (rd_data),
        .rd_perr              (rd_perr),
        .irq                  (irq)
`ifdef SL_RX_ERR_CNT_EN
        ,
        .err_cnt_w            (err_cnt_w)
`endif
    );

    always #31.25 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a word leaves the FIFO on the edge after it is seen valid and ready.
    always @(negedge clk) begin
        if (rst_n && rd_valid && rd_ready) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_word: got 0x%0h, expected no word", rd_data);
            end else begin
                mon_e = sb.pop_front();
                check("rd_data", rd_data, mon_e.data);
                check("rd_perr", 32'(rd_perr), 32'(mon_e.perr));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_sym(input logic z, input logic o);
        serial_line_zeroes_a = z;
        serial_line_ones_a   = o;
        tick(7);
        serial_line_zeroes_a = 1'b1;
        serial_line_ones_a   = 1'b1;
        tick(7);
    endtask

    task automatic send_bit(input logic b);
        if (b) send_sym(1'b1, 1'b0);
        else   send_sym(1'b0, 1'b1);
    endtask

    task automatic send_bits(input logic [31:0] data, input int n);
        for (int i = 0; i < n; i++) send_bit(data[i]);
    endtask

    task automatic send_word(input logic [31:0] data, input int nbits, input logic bad_par);
        logic [31:0] mask;
        logic        par;
        mask = (nbits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << nbits) - 32'd1);
        par  = (~^(data & mask)) ^ bad_par;
        send_bits(data, nbits);
        send_bit(par);
        send_sym(1'b0, 1'b0);
        tick(4);
    endtask

    task automatic expect_word(input logic [31:0] data, input logic perr);
        exp_t e;
        e.data = data;
        e.perr = perr;
        sb.push_back(e);
    endtask

    task automatic write_cfg(input logic [15:0] v);
        wr_config_w = v;
        wr_enable   = 1'b1;
        tick(1);
        wr_enable   = 1'b0;
        tick(1);
    endtask

    task automatic clear_status();
        status_clr = 1'b1;
        tick(1);
        status_clr = 1'b0;
        tick(1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        rd_ready = 1'b1;
        while (rd_valid && n < 40) begin
            tick(1);
            n++;
        end
        tick(1);
        check("drain_empty", 32'(rd_valid), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick(3);
        rst_n = 1'b1;
        tick(2);
        check("reset_status", 32'(status_w), 32'h0);
        check("reset_config", 32'(r_config_w), 32'h0010);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_rd_data", rd_data, 32'h0);
        check("reset_rd_perr", 32'(rd_perr), 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        tick(10);

        // Default config: one word held in the FIFO, then drained.
        rd_ready = 1'b0;
        expect_word(32'h0000_00A5, 1'b0);
        send_word(32'hA5, 8, 1'b0);
        check("a5_valid", 32'(rd_valid), 32'd1);
        check("a5_status_count1", 32'(status_w), 32'h0100);
        check("a5_irq_masked", 32'(irq), 32'd0);
        drain();
        check("a5_status_after", 32'(status_w), 32'h0);

        // Parity checking on, bad parity: word still delivered, PEF set.
        write_cfg(16'h0011);
        check("cfg_pce", 32'(r_config_w), 32'h0011);
        rd_ready = 1'b1;
        expect_word(32'h0000_0001, 1'b1);
        send_word(32'h01, 8, 1'b1);
        check("pef_status", 32'(status_w), 32'h0004);
        clear_status();
        check("pef_cleared", 32'(status_w), 32'h0);

        // Overflow: five words into a four-deep FIFO with the consumer stalled.
        write_cfg(16'h0110);
        check("cfg_irqm", 32'(r_config_w), 32'h0110);
        rd_ready = 1'b0;
        expect_word(32'h11, 1'b0);
        expect_word(32'h22, 1'b0);
        expect_word(32'h33, 1'b0);
        expect_word(32'h44, 1'b0);
        send_word(32'h11, 8, 1'b0);
        send_word(32'h22, 8, 1'b0);
        send_word(32'h33, 8, 1'b0);
        send_word(32'h44, 8, 1'b0);
        send_word(32'h55, 8, 1'b0);
        check("ovf_status", 32'(status_w), 32'h0410);
        check("ovf_irq_avail", 32'(irq), 32'd1);
        drain();
        check("ovf_sticky", 32'(status_w), 32'h0010);
        clear_status();
        check("ovf_cleared", 32'(status_w), 32'h0);

        // Short word: stop after six bits, then a normal word.
        send_bits(32'b101101, 6);
        send_sym(1'b0, 1'b0);
        tick(4);
        check("wle_status", 32'(status_w), 32'h0002);
        expect_word(32'h3C, 1'b0);
        send_word(32'h3C, 8, 1'b0);
        check("wle_then_word", 32'(status_w), 32'h0002);
        clear_status();

        // Ones line stuck low.
        serial_line_ones_a = 1'b0;
        tick(20);
        serial_line_ones_a = 1'b1;
        tick(14);
        check("lef_status", 32'(status_w), 32'h0008);
        clear_status();

        // Stall mid-word: partial word times out and is discarded.
        send_bits(32'b101, 3);
        check("wrp_midword", 32'(status_w), 32'h0001);
        tick(70);
        check("tof_status", 32'(status_w), 32'h0020);
        expect_word(32'h96, 1'b0);
        send_word(32'h96, 8, 1'b0);
        clear_status();
        check("tof_cleared", 32'(status_w), 32'h0);

        // Config write rules.
        write_cfg(16'h000E);
        check("cfg_odd_bq_ignored", 32'(r_config_w), 32'h0110);
        check("cfg_odd_bq_cfe", 32'(status_w), 32'h0040);
        clear_status();
        send_bits(32'b11, 2);
        write_cfg(16'h0020);
        check("cfg_midword_ignored", 32'(r_config_w), 32'h0110);
        check("cfg_midword_status", 32'(status_w), 32'h0041);
        tick(70);
        clear_status();
        write_cfg(16'h0020);
        check("cfg_bq16", 32'(r_config_w), 32'h0020);
        check("cfg_bq16_status", 32'(status_w), 32'h0);
        expect_word(32'h0000_BEEF, 1'b0);
        send_word(32'hBEEF, 16, 1'b0);
        check("bq16_status", 32'(status_w), 32'h0);

        tick(10);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
